calc_alu: RTL and testbench
===========================

Name: calc_alu

Overview:
Sequential arithmetic core of the calculator; sits directly upstream of the seven-segment display driver and feeds its ind_from_ALU and c_from_ALU inputs.
- Captures two 4-bit operands from the switches via the key buttons.
- On an operation button press, computes sum, difference, product or fixed-point quotient.
- Holds the result and a display code until the next operation.
- Division uses an iterative restoring divider; the other operations complete in one cycle.

Parameters:
DEB_W, 16, debounce counter width; a button level is accepted after it is stable for 2^DEB_W consecutive Clk cycles
DIV_STEPS, 11, restoring-divider iterations (dividend width)

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous active-high reset
sw  input  4  operand value from switches (unsigned 0..15)
keys  input  2  active-low buttons: keys[0] latches A, keys[1] latches B
arifs  input  4  active-low operation buttons: [0] add, [1] sub, [2] mul, [3] div
ind_from_ALU  output  11  result magnitude (unsigned)
c_from_ALU  output  3  display code: 0 plain, 1 negative, 2 divide-by-zero, 4 quotient with two decimal places
busy  output  1  high while a division is iterating

Behaviour:
- Reset (Rst high at a Clk edge):
  - A=0, B=0, ind_from_ALU=0, c_from_ALU=0, busy=0, FSM=IDLE.
  - Synchronizer flops=1 (released), debounce counters=0, debounced levels=1.
  - Reset mid-division aborts it; no partial result reaches the outputs.
- Input conditioning (all 6 buttons):
  - Two-flop synchronizer, then debounce. The debounced level changes only after the synchronized level differs from it for 2^DEB_W consecutive cycles. Any bounce restarts the counter.
  - A one-cycle strobe is generated on the debounced 1->0 transition.
  - Holding a button produces exactly one strobe.
- Operand capture:
  - A key strobe in IDLE loads A<=sw (keys[0]) or B<=sw (keys[1]). Both may load in the same cycle.
  - Key strobes while busy are ignored.
  - Outputs are not changed by operand capture.
- Operation select:
  - Op strobes are accepted only in IDLE.
  - Simultaneous op strobes resolve by priority add > sub > mul > div.
  - Strobes while busy are dropped, not queued.
- FSM IDLE -> (op strobe) -> EXEC or DIV.
- EXEC (one cycle): outputs update on the edge after the strobe cycle, i.e. latency 1.
  - add: result = A+B (0..30), code 0.
  - sub: if A>=B, result = A-B, code 0. Otherwise result = B-A, code 1. Zero difference gives code 0.
  - mul: result = A*B (0..225), code 0.
  - Returns to IDLE.
- div with B==0: handled in EXEC; result = 0, code 2, latency 1.
- div with B!=0, DIV state:
  - Load dividend D = A*100 (11 bits, max 1500), divisor B, partial remainder 0, busy=1.
  - Run DIV_STEPS restoring iterations, MSB first, one per cycle.
  - On the final iteration, write result = floor(A*100/B), code 4, clear busy and return to IDLE.
  - Total latency is 12 cycles from the strobe cycle to updated outputs (busy high for cycles 1..11). Max result 1500 < 2048, so no overflow.
- Outputs are registered and held stable between operations. They never glitch during division; the previous result stays visible until completion.
- All arithmetic is unsigned. Intermediates are wide enough that no carry is lost (11 bits for results, 5 bits for the divider remainder).

Test Plan:
- Bench uses DEB_W=2.
- Reset: assert Rst for 3 cycles with buttons idle high -> ind_from_ALU=0, c_from_ALU=0, busy=0. Assert Rst during a division -> busy=0 next edge, outputs 0.
- Add/mul: sw=9 press keys[0], sw=7 press keys[1], press arifs[0] -> 16/code 0 one cycle after strobe. Press arifs[2] -> 63/code 0.
- Subtract sign: A=3, B=12, arifs[1] -> 9/code 1. A=B=5 -> 0/code 0.
- Division: A=10, B=3, arifs[3] -> busy high 11 cycles, then 333/code 4. A=15, B=1 -> 1500/code 4. A=0, B=7 -> 0/code 4.
- Divide by zero: B=0, arifs[3] -> 0/code 2 after 1 cycle, busy never asserted.
- Debounce and concurrency:
  - arifs[0] toggling every cycle -> no strobe.
  - Held low 20 cycles -> exactly one operation.
  - arifs[0] and arifs[2] pressed together -> add result.
  - Add or key press during division -> ignored; A unchanged, division result correct.

Source files
------------

// File: rtl/calc_alu.sv
// -----------------------------------------------------------------------------
// calc_alu -- sequential arithmetic core of the calculator.
//
// Two 4-bit operands are captured from the switches with the key buttons. An
// operation button then computes a sum, a difference, a product or a
// fixed-point quotient (A*100/B). The result magnitude and a display code are
// held until the next operation. Division runs an iterative restoring divider.
// Every other operation completes in one cycle.
//
// All six buttons are active-low. Each one passes through a two-flop
// synchronizer and a debouncer. Each debounced press produces exactly one
// single-cycle strobe.
//
// Ports
//   Clk           system clock
//   Rst           synchronous active-high reset
//   sw[3:0]       operand value from the switches (unsigned 0..15)
//   keys[1:0]     active-low: [0] latches A, [1] latches B
//   arifs[3:0]    active-low: [0] add, [1] sub, [2] mul, [3] div
//   ind_from_ALU  result magnitude (unsigned, 11 bits)
//   c_from_ALU    display code: 0 plain, 1 negative, 2 divide-by-zero,
//                 4 quotient with two decimal places
//   busy          high while a division is iterating
//
// Parameters
//   DEB_W      a level is accepted after 2^DEB_W stable cycles
//   DIV_STEPS  restoring-divider iterations (dividend width)
// -----------------------------------------------------------------------------
module calc_alu #(
    parameter int DEB_W     = 16,
    parameter int DIV_STEPS = 11
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [3:0]  sw,
    input  logic [1:0]  keys,
    input  logic [3:0]  arifs,
    output logic [10:0] ind_from_ALU,
    output logic [2:0]  c_from_ALU,
    output logic        busy
);

    localparam int NBTN   = 6;
    localparam int RES_W  = 11;
    localparam int STEP_W = $clog2(DIV_STEPS + 1);

    localparam logic [DEB_W-1:0] CNT_MAX = {DEB_W{1'b1}};

    localparam logic [2:0] CODE_PLAIN = 3'd0;
    localparam logic [2:0] CODE_NEG   = 3'd1;
    localparam logic [2:0] CODE_DIV0  = 3'd2;
    localparam logic [2:0] CODE_FRAC  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV
    } state_t;

    // -------------------------------------------------------------------------
    // Button conditioning
    // -------------------------------------------------------------------------
    // Bits [1:0] are the operand keys. Bits [5:2] are the operation buttons.
    logic [NBTN-1:0] btn_raw;
    assign btn_raw = {arifs, keys};

    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  level_q, level_d;
    logic [NBTN-1:0]  fall_q,  fall_d;
    logic [DEB_W-1:0] cnt_q [NBTN];
    logic [DEB_W-1:0] cnt_d [NBTN];

    // NOTE: every variable gets a default at the top of an always_comb, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            // The counter runs only while the synchronized level disagrees
            // with the accepted level. Any agreement (a bounce) clears it.
            // The level flips on the 2^DEB_W-th consecutive disagreement.
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        // One-cycle strobe on an accepted 1->0 (press) transition.
        fall_d = level_q & ~level_d;
    end

    logic [1:0] key_stb;
    logic [3:0] op_stb;
    assign key_stb = fall_q[1:0];
    assign op_stb  = fall_q[5:2];

    // -------------------------------------------------------------------------
    // Datapath / FSM state
    // -------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        a_q, a_d;
    logic [3:0]        b_q, b_d;
    logic [RES_W-1:0]  ind_q, ind_d;
    logic [2:0]        code_q, code_d;
    logic              busy_q, busy_d;
    // The dividend register also collects quotient bits. Each step shifts one
    // dividend bit out of the top and one quotient bit into the bottom.
    logic [RES_W-1:0]  dvd_q, dvd_d;
    logic [3:0]        dsr_q, dsr_d;
    logic [4:0]        rem_q, rem_d;
    logic [STEP_W-1:0] step_q, step_d;

    // A*100 peaks at 1500, which fits in 11 bits.
    logic [RES_W-1:0] a_x100;
    assign a_x100 = RES_W'(a_q) * RES_W'(100);

    // One restoring-division step. The remainder is always below the divisor
    // (at most 15). After the shift it stays below 32, so the 6-bit trial
    // value never loses a carry.
    logic [5:0]       rem_shift;
    logic             rem_geq;
    logic [4:0]       rem_step;
    logic [RES_W-1:0] dvd_step;

    always_comb begin
        rem_shift = {rem_q, dvd_q[RES_W-1]};
        rem_geq   = (rem_shift >= {2'b00, dsr_q});
        rem_step  = rem_geq ? 5'(rem_shift - {2'b00, dsr_q}) : rem_shift[4:0];
        dvd_step  = {dvd_q[RES_W-2:0], rem_geq};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ind_d   = ind_q;
        code_d  = code_q;
        busy_d  = busy_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        step_d  = step_q;

        unique case (state_q)
            ST_IDLE: begin
                // The operands update on the same edge as an operation
                // strobe. The operation itself uses the values held before
                // that edge.
                if (key_stb[0]) a_d = sw;
                if (key_stb[1]) b_d = sw;

                // Fixed priority: add > sub > mul > div.
                if (op_stb[0]) begin
                    ind_d   = RES_W'(a_q) + RES_W'(b_q);
                    code_d  = CODE_PLAIN;
                    state_d = ST_EXEC;
                end else if (op_stb[1]) begin
                    if (a_q >= b_q) begin
                        ind_d  = RES_W'(a_q - b_q);
                        code_d = CODE_PLAIN;
                    end else begin
                        ind_d  = RES_W'(b_q - a_q);
                        code_d = CODE_NEG;
                    end
                    state_d = ST_EXEC;
                end else if (op_stb[2]) begin
                    ind_d   = RES_W'(a_q) * RES_W'(b_q);
                    code_d  = CODE_PLAIN;
                    state_d = ST_EXEC;
                end else if (op_stb[3]) begin
                    if (b_q == 4'd0) begin
                        ind_d   = '0;
                        code_d  = CODE_DIV0;
                        state_d = ST_EXEC;
                    end else begin
                        dvd_d   = a_x100;
                        dsr_d   = b_q;
                        rem_d   = '0;
                        step_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_DIV;
                    end
                end
            end

            // Single-cycle operations already wrote their result on entry.
            // This state only closes out the operation.
            ST_EXEC: begin
                state_d = ST_IDLE;
            end

            ST_DIV: begin
                dvd_d  = dvd_step;
                rem_d  = rem_step;
                step_d = step_q + STEP_W'(1);
                // The outputs keep the previous result until the final
                // quotient bit is known.
                if (step_q == STEP_W'(DIV_STEPS - 1)) begin
                    ind_d   = dvd_step;
                    code_d  = CODE_FRAC;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops then
    // sample their _d values together, with no order dependence between them.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            level_q <= '1;
            fall_q  <= '0;
            // NOTE: this small counter array is built from flops, not RAM, so
            // it is reset element by element like any other state.
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= '0;
            end
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ind_q   <= '0;
            code_q  <= CODE_PLAIN;
            busy_q  <= 1'b0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            step_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            for (int i = 0; i < NBTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ind_q   <= ind_d;
            code_q  <= code_d;
            busy_q  <= busy_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            step_q  <= step_d;
        end
    end

    assign ind_from_ALU = ind_q;
    assign c_from_ALU   = code_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_calc_alu.sv
// -----------------------------------------------------------------------------
// tb_calc_alu -- self-checking bench for calc_alu.
//
// A behavioural model steps once per rising edge, using the bench's own
// stimulus. It tracks the raw button history, accepts a level once the
// synchronized samples have disagreed for 2^DEB_W edges, and then applies the
// operation rules with plain arithmetic. Division is modelled as a fixed wait
// followed by A*100/B. A compare process checks the DUT against the model on
// every falling edge. Directed sequences with hand-computed results pin the
// model, and a randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_calc_alu;

    localparam int DEB_W     = 2;
    localparam int DEB_LEN   = 1 << DEB_W;
    localparam int DIV_STEPS = 11;
    localparam int HIST      = DEB_LEN + 3;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [3:0]  sw;
    logic [1:0]  keys;
    logic [3:0]  arifs;
    logic [10:0] ind_from_ALU;
    logic [2:0]  c_from_ALU;
    logic        busy;

    always #5 Clk = ~Clk;

    calc_alu #(
        .DEB_W     (DEB_W),
        .DIV_STEPS (DIV_STEPS)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .sw           (sw),
        .keys         (keys),
        .arifs        (arifs),
        .ind_from_ALU (ind_from_ALU),
        .c_from_ALU   (c_from_ALU),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time,
                     actual, expected);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int m_a, m_b, m_ind, m_code, m_pending, m_wait;
    bit m_busy, m_in_div;
    bit m_level [6];
    bit m_fall  [6];
    bit m_hist  [6][HIST];   // m_hist[i][k] = raw level of button i, k edges ago

    always @(posedge Clk) begin : model
        logic [5:0] raw;
        int         op;
        bit         differ;
        raw = {arifs, keys};
        if (Rst) begin
            m_a = 0; m_b = 0; m_ind = 0; m_code = 0;
            m_busy = 0; m_in_div = 0; m_wait = 0; m_pending = 0;
            for (int i = 0; i < 6; i++) begin
                m_level[i] = 1'b1;
                m_fall[i]  = 1'b0;
                for (int k = 0; k < HIST; k++) m_hist[i][k] = 1'b1;
            end
        end else begin
            // Act on the strobes produced one edge earlier.
            if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0 && m_in_div) begin
                    m_ind    = m_pending;
                    m_code   = 4;
                    m_busy   = 0;
                    m_in_div = 0;
                end
            end else begin
                op = -1;
                for (int i = 3; i >= 0; i--) if (m_fall[2 + i]) op = i;
                case (op)
                    0: begin m_ind = m_a + m_b; m_code = 0; m_wait = 1; end
                    1: begin
                        if (m_a >= m_b) begin m_ind = m_a - m_b; m_code = 0; end
                        else            begin m_ind = m_b - m_a; m_code = 1; end
                        m_wait = 1;
                    end
                    2: begin m_ind = m_a * m_b; m_code = 0; m_wait = 1; end
                    3: begin
                        if (m_b == 0) begin
                            m_ind = 0; m_code = 2; m_wait = 1;
                        end else begin
                            m_pending = (m_a * 100) / m_b;
                            m_busy    = 1;
                            m_in_div  = 1;
                            m_wait    = DIV_STEPS;
                        end
                    end
                    default: ;
                endcase
                if (m_fall[0]) m_a = int'(sw);
                if (m_fall[1]) m_b = int'(sw);
            end
            // The level seen by the debouncer trails the pin by two edges.
            for (int i = 0; i < 6; i++) begin
                for (int k = HIST - 1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
                m_hist[i][0] = raw[i];
                differ = 1'b1;
                for (int k = 2; k < 2 + DEB_LEN; k++)
                    if (m_hist[i][k] == m_level[i]) differ = 1'b0;
                m_fall[i] = m_level[i] & differ;
                if (differ) m_level[i] = ~m_level[i];
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("ind",  32'(ind_from_ALU), 32'(m_ind));
            check("code", 32'(c_from_ALU),   32'(m_code));
            check("busy", 32'(busy),         32'(m_busy));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic set_btn(input int btn, input bit v);
        if (btn < 2) keys[btn] = v;
        else         arifs[btn-2] = v;
    endtask

    task automatic press(input int btn, input int hold);
        set_btn(btn, 1'b0);
        repeat (hold) @(negedge Clk);
        set_btn(btn, 1'b1);
        repeat (10) @(negedge Clk);
    endtask

    task automatic load(input int btn, input int val);
        sw = 4'(val);
        press(btn, 8);
    endtask

    task automatic do_op(input int btn);
        press(btn, 8);
        repeat (6) @(negedge Clk);
    endtask

    task automatic run_div(output int busy_cycles);
        busy_cycles = 0;
        set_btn(5, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (busy) busy_cycles++;
            if (i == 8) set_btn(5, 1'b1);
        end
    endtask

    task automatic wait_busy();
        for (int i = 0; i < 20 && busy !== 1'b1; i++) @(negedge Clk);
        check("div_start", 32'(busy), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int bc;
        Rst = 1'b1; sw = '0; keys = 2'b11; arifs = 4'hF;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_ind",  32'(ind_from_ALU), 32'd0);
        check("rst_code", 32'(c_from_ALU),   32'd0);
        check("rst_busy", 32'(busy),         32'd0);

        // Add / mul
        load(0, 9); load(1, 7);
        do_op(2);
        check("add_9_7",  32'(ind_from_ALU), 32'd16);
        check("add_code", 32'(c_from_ALU),   32'd0);
        do_op(4);
        check("mul_9_7",  32'(ind_from_ALU), 32'd63);

        // Subtract sign handling
        load(0, 3); load(1, 12);
        do_op(3);
        check("sub_3_12",      32'(ind_from_ALU), 32'd9);
        check("sub_3_12_code", 32'(c_from_ALU),   32'd1);
        load(0, 5); load(1, 5);
        do_op(3);
        check("sub_5_5",      32'(ind_from_ALU), 32'd0);
        check("sub_5_5_code", 32'(c_from_ALU),   32'd0);

        // Division
        load(0, 10); load(1, 3);
        run_div(bc);
        check("div_busy_len", 32'(bc),            32'd11);
        check("div_10_3",     32'(ind_from_ALU),  32'd333);
        check("div_code",     32'(c_from_ALU),    32'd4);
        load(0, 15); load(1, 1);
        run_div(bc);
        check("div_15_1", 32'(ind_from_ALU), 32'd1500);
        load(0, 0); load(1, 7);
        run_div(bc);
        check("div_0_7",      32'(ind_from_ALU), 32'd0);
        check("div_0_7_code", 32'(c_from_ALU),   32'd4);

        // Divide by zero
        load(0, 9); load(1, 0);
        run_div(bc);
        check("div0_busy", 32'(bc),           32'd0);
        check("div0_ind",  32'(ind_from_ALU), 32'd0);
        check("div0_code", 32'(c_from_ALU),   32'd2);

        // A chattering button never produces a strobe
        load(0, 2); load(1, 3);
        for (int i = 0; i < 20; i++) begin
            arifs[0] = ~arifs[0];
            @(negedge Clk);
        end
        arifs[0] = 1'b1;
        repeat (10) @(negedge Clk);
        check("bounce_code", 32'(c_from_ALU), 32'd2);

        // Long hold gives a single add
        press(2, 20);
        check("hold_add", 32'(ind_from_ALU), 32'd5);

        // Simultaneous add and mul: add wins
        load(0, 4); load(1, 6);
        arifs[0] = 1'b0; arifs[2] = 1'b0;
        repeat (8) @(negedge Clk);
        arifs = 4'hF;
        repeat (10) @(negedge Clk);
        check("prio_add", 32'(ind_from_ALU), 32'd10);

        // Key and add presses during a division are dropped
        load(0, 10); load(1, 3);
        arifs[3] = 1'b0;
        wait_busy();
        arifs[3] = 1'b1;
        sw = 4'd2; keys[0] = 1'b0; arifs[0] = 1'b0;
        repeat (8) @(negedge Clk);
        keys[0] = 1'b1; arifs[0] = 1'b1;
        repeat (20) @(negedge Clk);
        check("div_ignore", 32'(ind_from_ALU), 32'd333);
        do_op(2);
        check("a_kept", 32'(ind_from_ALU), 32'd13);

        // Reset in the middle of a division
        load(0, 15); load(1, 1);
        arifs[3] = 1'b0;
        wait_busy();
        arifs[3] = 1'b1;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("rst_div_busy", 32'(busy),         32'd0);
        check("rst_div_ind",  32'(ind_from_ALU), 32'd0);
        check("rst_div_code", 32'(c_from_ALU),   32'd0);
        Rst = 1'b0;
        repeat (20) @(negedge Clk);
        check("rst_div_held", 32'(ind_from_ALU), 32'd0);

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            @(negedge Clk);
            sw = 4'($urandom_range(0, 15));
            for (int b = 0; b < 6; b++) begin
                if ($urandom_range(0, 9) == 0) begin
                    if (b < 2) keys[b] = ~keys[b];
                    else       arifs[b-2] = ~arifs[b-2];
                end
            end
            Rst = ($urandom_range(0, 999) == 0);
        end
        Rst = 1'b0; keys = 2'b11; arifs = 4'hF;
        repeat (30) @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
